// File: rtl/rf_text_pkg.sv
// Shared types and constants for the text-cell fetch path.
// Holds the fetch state encoding and the default screen RAM size.
package rf_text_pkg;

    localparam int unsigned TEXT_CELL_COUNT_DFLT = 16384;
    localparam int unsigned CELL_W               = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/rf_text_cell_fifo.sv
// Synchronous cell buffer with occupancy count and a single-cycle flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module rf_text_cell_fifo
    import rf_text_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = CELL_W,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_vld,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop: flush discards both, and full/empty block them.
    always_comb begin
        do_push_s = push && !flush && (count_r != CW'(DEPTH));
        do_pop_s  = pop && !flush && (count_r != {CW{1'b0}});
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Cell storage; contents only matter where count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Head presentation, forced to zero whenever the buffer is empty.
    always_comb begin
        rd_vld = (count_r != {CW{1'b0}});
        count  = count_r;
        if (rd_vld) begin
            rd_data = mem_r[rd_ptr_r];
        end else begin
            rd_data = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/rf_text_cell_fetch.sv
// Fetches one row of 64-bit text cells from screen RAM into a small buffer.
// Optional underrun counter is built when RF_TEXT_FETCH_UNDERRUN_EN is defined.
module rf_text_cell_fetch
    import rf_text_pkg::*;
#(
    parameter  int unsigned TEXT_CELL_COUNT = TEXT_CELL_COUNT_DFLT,
    parameter  int unsigned FIFO_DEPTH      = 4,
    localparam int unsigned AWID            = $clog2(TEXT_CELL_COUNT)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [AWID-1:0] row_base_i,
    input  logic [7:0]      cols_i,
    output logic            ram_cs_o,
    output logic [AWID-1:0] ram_adr_o,
    input  logic [63:0]     ram_dat_i,
    output logic [63:0]     cell_o,
    output logic            cell_vld_o,
    input  logic            cell_rdy_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [15:0]     underrun_cnt_o
);

    localparam int unsigned     CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned     IW       = CW + 1;
    localparam logic [AWID-1:0] LAST_ADR = AWID'(TEXT_CELL_COUNT - 1);

    fetch_state_e    state_r;
    fetch_state_e    state_step_s;
    fetch_state_e    state_nxt_s;
    logic [7:0]      cols_r;
    logic [7:0]      issued_r;
    logic [7:0]      xfer_r;
    logic            ram_cs_r;
    logic [AWID-1:0] ram_adr_r;
    logic            pend_r;
    logic            done_r;
    logic [CW-1:0]   count_s;
    logic [IW-1:0]   inflight_s;
    logic            fifo_vld_s;
    logic [63:0]     fifo_dat_s;
    logic            issue_s;
    logic            pop_s;
    logic            final_xfer_s;
    logic [AWID-1:0] adr_inc_s;

    rf_text_cell_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .flush   (start_i),
        .push    (pend_r),
        .wr_data (ram_dat_i),
        .pop     (pop_s),
        .rd_data (fifo_dat_s),
        .rd_vld  (fifo_vld_s),
        .count   (count_s)
    );

    // Transfer detection, buffer pressure and the wrapped next address.
    always_comb begin
        pop_s        = fifo_vld_s && cell_rdy_i;
        final_xfer_s = pop_s && (state_r != IDLE) && (xfer_r == (cols_r - 8'd1));
        // Occupancy plus the read on the bus plus the read whose data lands this cycle.
        inflight_s   = {1'b0, count_s} + IW'(ram_cs_r) + IW'(pend_r);
        if (ram_adr_r == LAST_ADR) begin
            adr_inc_s = {AWID{1'b0}};
        end else begin
            adr_inc_s = ram_adr_r + AWID'(1);
        end
    end

    // Next-state and read-issue decision; a start request overrides everything.
    always_comb begin
        state_step_s = state_r;
        state_nxt_s  = state_r;
        issue_s      = 1'b0;
        case (state_r)
            IDLE: begin
                state_step_s = IDLE;
            end
            FETCH: begin
                if (issued_r == cols_r) begin
                    state_step_s = DRAIN;
                end else begin
                    state_step_s = FETCH;
                    issue_s      = (inflight_s < IW'(FIFO_DEPTH));
                end
            end
            DRAIN: begin
                if (final_xfer_s) begin
                    state_step_s = IDLE;
                end else begin
                    state_step_s = DRAIN;
                end
            end
            default: begin
                state_step_s = IDLE;
            end
        endcase
        if (start_i) begin
            if (cols_i != 8'd0) begin
                state_nxt_s = FETCH;
            end else begin
                state_nxt_s = IDLE;
            end
        end else begin
            state_nxt_s = state_step_s;
        end
    end

    // Row control: capture the request, sequence reads, count transfers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            cols_r    <= 8'd0;
            issued_r  <= 8'd0;
            xfer_r    <= 8'd0;
            ram_cs_r  <= 1'b0;
            ram_adr_r <= {AWID{1'b0}};
            pend_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            // A restart drops the data of any read already on the bus.
            pend_r  <= ram_cs_r && !start_i;
            if (start_i) begin
                cols_r <= cols_i;
                xfer_r <= 8'd0;
                done_r <= (cols_i == 8'd0);
                if (cols_i != 8'd0) begin
                    ram_cs_r  <= 1'b1;
                    ram_adr_r <= row_base_i;
                    issued_r  <= 8'd1;
                end else begin
                    ram_cs_r <= 1'b0;
                    issued_r <= 8'd0;
                end
            end else begin
                done_r   <= final_xfer_s;
                ram_cs_r <= issue_s;
                if (issue_s) begin
                    ram_adr_r <= adr_inc_s;
                    issued_r  <= issued_r + 8'd1;
                end
                if (pop_s) begin
                    xfer_r <= xfer_r + 8'd1;
                end
            end
        end
    end

`ifdef RF_TEXT_FETCH_UNDERRUN_EN
    logic [15:0] underrun_r;

    // Saturating count of cycles where the consumer waits on an empty buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            underrun_r <= 16'h0000;
        end else if ((state_r != IDLE) && cell_rdy_i && !fifo_vld_s && (underrun_r != 16'hFFFF)) begin
            underrun_r <= underrun_r + 16'h0001;
        end
    end

    assign underrun_cnt_o = underrun_r;
`else
    assign underrun_cnt_o = 16'h0000;
`endif

    assign ram_cs_o   = ram_cs_r;
    assign ram_adr_o  = ram_adr_r;
    assign cell_o     = fifo_dat_s;
    assign cell_vld_o = fifo_vld_s;
    assign busy_o     = (state_r != IDLE);
    assign done_o     = done_r;

endmodule

// File: tb/tb_rf_text_cell_fetch.sv
// Self-checking bench for rf_text_cell_fetch: directed rows, corner sequences
// and randomized rows checked against a queue-based row model.
module tb_rf_text_cell_fetch;

    localparam int N     = 16384;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [13:0] row_base_i = 14'd0;
    logic [7:0]  cols_i = 8'd0;
    logic        ram_cs_o;
    logic [13:0] ram_adr_o;
    logic [63:0] ram_dat_i = 64'd0;
    logic [63:0] cell_o;
    logic        cell_vld_o;
    logic        cell_rdy_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [15:0] underrun_cnt_o;

    rf_text_cell_fetch #(.TEXT_CELL_COUNT(16384), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .row_base_i(row_base_i),
        .cols_i(cols_i), .ram_cs_o(ram_cs_o), .ram_adr_o(ram_adr_o), .ram_dat_i(ram_dat_i),
        .cell_o(cell_o), .cell_vld_o(cell_vld_o), .cell_rdy_i(cell_rdy_i),
        .busy_o(busy_o), .done_o(done_o), .underrun_cnt_o(underrun_cnt_o)
    );

    always #5 clk = ~clk;

`ifdef RF_TEXT_FETCH_UNDERRUN_EN
    localparam int UR_PER_ROW = 2;
`else
    localparam int UR_PER_ROW = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Row model: what must be read and delivered, in order.
    logic [13:0] exp_addr_q[$];
    logic [63:0] exp_cell_q[$];
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic        nd_m, nb_m;
    logic [13:0] a_m;
    int          n_done = 0, n_reads = 0, reads_row = 0, xfers_row = 0;
    logic        first_pend = 1'b0;
    logic [13:0] first_adr = 14'd0, last_adr = 14'd0;

    function automatic logic [63:0] cell_of(input logic [13:0] a);
        return {16'hC0DE, 2'b00, a, 18'h0, ~a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RAM port B: one-cycle read latency, garbage when not enabled.
    always @(posedge clk) begin
        if (ram_cs_o) ram_dat_i <= cell_of(ram_adr_o);
        else          ram_dat_i <= {$urandom, $urandom};
    end

    // Monitor and reference model, evaluated mid-cycle.
    always @(negedge clk) begin
        if (rst_i) begin
            exp_addr_q.delete();
            exp_cell_q.delete();
            exp_busy = 1'b0;
            exp_done = 1'b0;
            first_pend = 1'b0;
        end else begin
            check("done", 64'(done_o), 64'(exp_done));
            check("busy", 64'(busy_o), 64'(exp_busy));
            if (done_o) n_done++;
            if (!exp_busy) check("idle_vld", 64'(cell_vld_o), 64'd0);
            nd_m = 1'b0;
            nb_m = exp_busy;
            if (ram_cs_o) begin
                n_reads++;
                reads_row++;
                if (first_pend) begin
                    first_adr = ram_adr_o;
                    first_pend = 1'b0;
                end
                last_adr = ram_adr_o;
                check("read_expected", 64'(exp_addr_q.size() != 0), 64'd1);
                if (exp_addr_q.size() != 0) check("ram_adr", 64'(ram_adr_o), 64'(exp_addr_q.pop_front()));
                check("fifo_room", 64'((reads_row - xfers_row) <= DEPTH), 64'd1);
            end
            if (cell_vld_o && !cell_rdy_i && exp_cell_q.size() != 0)
                check("stall_head", cell_o, exp_cell_q[0]);
            if (cell_vld_o && cell_rdy_i) begin
                xfers_row++;
                check("cell_expected", 64'(exp_cell_q.size() != 0), 64'd1);
                if (exp_cell_q.size() != 0) begin
                    check("cell", cell_o, exp_cell_q.pop_front());
                    if (exp_cell_q.size() == 0 && exp_busy) begin
                        nd_m = 1'b1;
                        nb_m = 1'b0;
                    end
                end
            end
            if (start_i) begin
                exp_addr_q.delete();
                exp_cell_q.delete();
                reads_row = 0;
                xfers_row = 0;
                first_pend = (cols_i != 8'd0);
                nd_m = (cols_i == 8'd0);
                nb_m = (cols_i != 8'd0);
                for (int i = 0; i < int'(cols_i); i++) begin
                    a_m = 14'((int'(row_base_i) + i) % N);
                    exp_addr_q.push_back(a_m);
                    exp_cell_q.push_back(cell_of(a_m));
                end
            end
            exp_done = nd_m;
            exp_busy = nb_m;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic start_row(input logic [13:0] b, input logic [7:0] c);
        start_i = 1'b1;
        row_base_i = b;
        cols_i = c;
        tick();
        start_i = 1'b0;
    endtask

    task automatic run_to_done(input int budget, input bit rnd_rdy, output int lat);
        lat = 1;
        while (!done_o && lat < budget) begin
            if (rnd_rdy) cell_rdy_i = ($urandom_range(0, 3) != 0);
            tick();
            lat++;
        end
        check("done_seen", 64'(done_o), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs"}, 64'(ram_cs_o), 64'd0);
        check({tag, "_adr"}, 64'(ram_adr_o), 64'd0);
        check({tag, "_vld"}, 64'(cell_vld_o), 64'd0);
        check({tag, "_cell"}, cell_o, 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
        check({tag, "_ur"}, 64'(underrun_cnt_o), 64'd0);
    endtask

    typedef struct {
        logic [13:0] base;
        logic [7:0]  cols;
        logic [13:0] first_adr;
        logic [13:0] last_adr;
        int          lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat, r0, d0, k, ab;
        logic [15:0] u0;
        logic [13:0] b;
        logic [7:0]  c;

        vecs[0] = '{14'h0010, 8'd80,  14'h0010, 14'h005F, 83};
        vecs[1] = '{14'h3FFE, 8'd4,   14'h3FFE, 14'h0001, 7};
        vecs[2] = '{14'h3FF0, 8'd20,  14'h3FF0, 14'h0003, 23};
        vecs[3] = '{14'h0000, 8'd1,   14'h0000, 14'h0000, 4};
        vecs[4] = '{14'h2000, 8'd255, 14'h2000, 14'h20FE, 258};

        do_reset();
        check_reset_outputs("reset");

        // Full-rate rows from the table.
        cell_rdy_i = 1'b1;
        for (int v = 0; v < 5; v++) begin
            r0 = n_reads;
            d0 = n_done;
            u0 = underrun_cnt_o;
            start_row(vecs[v].base, vecs[v].cols);
            run_to_done(400, 1'b0, lat);
            check("tbl_latency", 64'(lat), 64'(vecs[v].lat));
            tick();
            check("tbl_reads", 64'(n_reads - r0), 64'(vecs[v].cols));
            check("tbl_first_adr", 64'(first_adr), 64'(vecs[v].first_adr));
            check("tbl_last_adr", 64'(last_adr), 64'(vecs[v].last_adr));
            check("tbl_done_once", 64'(n_done - d0), 64'd1);
            check("tbl_underrun", 64'(underrun_cnt_o - u0), 64'(UR_PER_ROW));
            check("tbl_drained", 64'(exp_cell_q.size()), 64'd0);
        end

        // Consumer stalled: reads stop at buffer depth, nothing lost on release.
        cell_rdy_i = 1'b0;
        r0 = n_reads;
        d0 = n_done;
        start_row(14'h0400, 8'd10);
        repeat (19) tick();
        check("bp_cs_idle", 64'(ram_cs_o), 64'd0);
        check("bp_reads", 64'(n_reads - r0), 64'(DEPTH));
        check("bp_head", cell_o, cell_of(14'h0400));
        cell_rdy_i = 1'b1;
        run_to_done(100, 1'b0, lat);
        tick();
        check("bp_total_reads", 64'(n_reads - r0), 64'd10);
        check("bp_done_once", 64'(n_done - d0), 64'd1);

        // Restart in the middle of a row.
        d0 = n_done;
        start_row(14'h0200, 8'd40);
        repeat (4) tick();
        start_row(14'h0100, 8'd8);
        k = 0;
        while (!cell_vld_o && k < 10) begin
            tick();
            k++;
        end
        check("abort_first_cell", cell_o, cell_of(14'h0100));
        run_to_done(100, 1'b0, lat);
        tick();
        check("abort_done_once", 64'(n_done - d0), 64'd1);

        // Empty row.
        d0 = n_done;
        r0 = n_reads;
        start_row(14'h0123, 8'd0);
        check("zero_done", 64'(done_o), 64'd1);
        check("zero_busy", 64'(busy_o), 64'd0);
        tick();
        check("zero_done_clear", 64'(done_o), 64'd0);
        tick();
        check("zero_reads", 64'(n_reads - r0), 64'd0);

        // Reset in the middle of a row; start during reset ignored.
        start_row(14'h0500, 8'd40);
        repeat (6) tick();
        rst_i = 1'b1;
        tick();
        check_reset_outputs("midrst");
        start_i = 1'b1;
        row_base_i = 14'h0600;
        cols_i = 8'd5;
        tick();
        rst_i = 1'b0;
        start_i = 1'b0;
        tick();
        tick();
        check("rst_start_busy", 64'(busy_o), 64'd0);
        check("rst_start_cs", 64'(ram_cs_o), 64'd0);

        // Underrun count of a fresh full-rate row of 8.
        do_reset();
        check("ur_cleared", 64'(underrun_cnt_o), 64'd0);
        cell_rdy_i = 1'b1;
        start_row(14'h0040, 8'd8);
        run_to_done(100, 1'b0, lat);
        tick();
        check("ur_row8", 64'(underrun_cnt_o), 64'(UR_PER_ROW));

        // Randomized rows, random backpressure, occasional restarts.
        for (int r = 0; r < 40; r++) begin
            b = 14'($urandom_range(0, N - 1));
            c = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 12)) : 0;
            cell_rdy_i = ($urandom_range(0, 3) != 0);
            start_row(b, c);
            lat = 1;
            while (!done_o && lat < 2000) begin
                if (lat == ab) begin
                    ab = 0;
                    b = 14'($urandom_range(0, N - 1));
                    c = 8'($urandom_range(1, 40));
                    start_row(b, c);
                    lat = 1;
                end else begin
                    cell_rdy_i = ($urandom_range(0, 3) != 0);
                    tick();
                    lat++;
                end
            end
            check("rnd_done", 64'(done_o), 64'd1);
            tick();
            check("rnd_drained", 64'(exp_cell_q.size()), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rf_text_cell_fetch.md
RF_TEXT_CELL_FETCH -- requirements
Module: rf_text_cell_fetch

Interface
REQ-001 SHALL have parameter TEXT_CELL_COUNT, default 16384, text cells in screen RAM; AWID = clog2(TEXT_CELL_COUNT).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, cell buffer entries (power of two, min 2).
REQ-003 SHALL have port clk_i input 1: sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_i input 1: reset, synchronous, active-high.
REQ-005 SHALL have port start_i input 1: one-cycle pulse, begin fetching a row.
REQ-006 SHALL have port row_base_i input AWID: cell index of first cell in row, sampled on start_i.
REQ-007 SHALL have port cols_i input 8: cells in row, sampled on start_i.
REQ-008 SHALL have port ram_cs_o output 1: RAM port-B enable, one read per asserted cycle.
REQ-009 SHALL have port ram_adr_o output AWID: RAM port-B cell address.
REQ-010 SHALL have port ram_dat_i input 64: RAM port-B read data, valid exactly 1 cycle after ram_cs_o.
REQ-011 SHALL have port cell_o output 64: head cell of buffer.
REQ-012 SHALL have port cell_vld_o output 1: cell_o valid.
REQ-013 SHALL have port cell_rdy_i input 1: consumer accepts; transfer when cell_vld_o & cell_rdy_i.
REQ-014 SHALL have port busy_o output 1: row in progress (FETCH or DRAIN).
REQ-015 SHALL have port done_o output 1: one-cycle pulse when last cell of row transferred.
REQ-016 SHALL have port underrun_cnt_o output 16: underrun count (see Configuration).

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN; IDLE->FETCH on start_i with cols_i!=0; FETCH->DRAIN when cols_i reads issued; DRAIN->IDLE on final transfer.
REQ-018 SHALL, on start_i with cols_i==0, stay IDLE, issue no read, pulse done_o next cycle.
REQ-019 SHALL issue a read in FETCH only when (occupancy + in-flight reads) < FIFO_DEPTH, guaranteeing no overflow.
REQ-020 SHALL drive ram_adr_o = row_base + issued count, modulo TEXT_CELL_COUNT (wrap to 0 past last cell).
REQ-021 SHALL write ram_dat_i into buffer the cycle after each issued read; read-to-cell_vld_o latency 2 cycles from empty.
REQ-022 SHALL present cells in address order, cell_o stable while cell_vld_o & !cell_rdy_i.
REQ-023 SHALL allow simultaneous buffer write and transfer in one cycle, occupancy unchanged.
REQ-024 SHALL sustain one cell/cycle throughput when cell_rdy_i held high.
REQ-025 SHALL, on start_i while busy_o, abort: flush buffer, discard in-flight read data, restart with new row next cycle; no done_o for aborted row.
REQ-026 SHALL assert done_o in same cycle the final transfer completes... registered: done_o high the cycle after final transfer.

Reset
REQ-027 SHALL, while rst_i, force state IDLE, buffer empty, in-flight cleared, ram_cs_o=0, ram_adr_o=0, cell_vld_o=0, cell_o=0, busy_o=0, done_o=0, underrun_cnt_o=0.
REQ-028 SHALL treat rst_i mid-row as full abort; start_i during rst_i ignored.

Configuration
REQ-029 SHALL, with RF_TEXT_FETCH_UNDERRUN_EN defined, increment underrun_cnt_o (saturating at 16'hFFFF) each cycle busy_o & cell_rdy_i & !cell_vld_o; cleared only by rst_i.
REQ-030 SHALL, without RF_TEXT_FETCH_UNDERRUN_EN, tie underrun_cnt_o to 0 and synthesize no counter.

Structure
REQ-031 SHALL place state enum (IDLE, FETCH, DRAIN) and default TEXT_CELL_COUNT constant in shared package rf_text_pkg.
REQ-032 SHALL implement buffer as sub-module rf_text_cell_fifo (synchronous FIFO, count output, flush input).

Verification
REQ-033 SHALL cover: row_base=0x0010, cols=80, cell_rdy_i=1 -> 80 reads 0x0010..0x005F, 80 cells in order, done_o once, underrun 0 after initial fill.
REQ-034 SHALL cover: row_base=0x3FFE, cols=4 -> addresses 0x3FFE,0x3FFF,0x0000,0x0001.
REQ-035 SHALL cover: cell_rdy_i=0 for 20 cycles after start, cols=10 -> exactly FIFO_DEPTH reads issued, ram_cs_o then 0, no loss on release.
REQ-036 SHALL cover: start_i at cycle 5 of 40-cell row, new base 0x0100 -> first cell after restart from 0x0100, no stale cell, one done_o.
REQ-037 SHALL cover: cols=0 -> no ram_cs_o, done_o pulse next cycle; rst_i mid-row -> all outputs reset values next cycle.
REQ-038 SHALL cover: macro defined, cell_rdy_i=1 with RAM stall-free row of 8 -> underrun_cnt_o=2 (initial fill); macro undefined -> 0.
